// File: rtl/score_display_pkg.sv
// Shared constants and types for the score_display seven-segment driver.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package score_disp_pkg;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam int unsigned CONV_ITERS = 6;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score-in / display-out bundle between the game side and score_display.
interface score_display_if;
  logic [5:0] score;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  modport master (output score, input seg, dp, an, busy);
  modport slave  (input score, output seg, dp, an, busy);
endinterface

// File: rtl/score_display_bin2bcd.sv
// Sequential shift-add-3 converter: 6-bit binary to two BCD digits.
// state    | meaning
// ST_IDLE  | waiting for start, tens/units hold last result
// ST_SHIFT | iterations 0..5 run, the 7th cycle publishes the digits
module bin2bcd_seq
  import score_disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       busy,
  output logic [3:0] tens,
  output logic [3:0] units
);

  conv_state_t state, state_nxt;
  logic [13:0] sr, sr_nxt;          // {tens, units, bin}
  logic [2:0]  iter, iter_nxt;
  logic [3:0]  tens_nxt, units_nxt;
  logic        busy_nxt;
  logic [7:0]  bcd_adj;

  always_comb begin
    bcd_adj = sr[13:6];
    if (sr[13:10] >= 4'd5) bcd_adj[7:4] = sr[13:10] + 4'd3;
    if (sr[9:6]   >= 4'd5) bcd_adj[3:0] = sr[9:6]   + 4'd3;
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    iter_nxt  = iter;
    tens_nxt  = tens;
    units_nxt = units;
    busy_nxt  = busy;
    case (state)
      ST_IDLE: begin
        if (start) begin
          sr_nxt    = {8'd0, bin};
          iter_nxt  = 3'd0;
          busy_nxt  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (iter == 3'(CONV_ITERS)) begin
          tens_nxt  = sr[13:10];
          units_nxt = sr[9:6];
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end else begin
          sr_nxt   = {bcd_adj, sr[5:0]} << 1;
          iter_nxt = iter + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sr    <= '0;
      iter  <= '0;
      tens  <= '0;
      units <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      iter  <= iter_nxt;
      tens  <= tens_nxt;
      units <= units_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: rtl/score_display.sv
// Score to Basys 3 seven-segment driver: change detect, BCD convert, digit mux.
// Define SCORE_DISP_LZB_EN to blank the tens digit when it is zero.
module score_display
  import score_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  score_display_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [5:0]       last_score;
  logic             start;
  logic             conv_busy;
  logic [3:0]       tens, units;
  logic [CNT_W-1:0] cnt;
  slot_t            slot;
  logic [3:0]       an_nxt, an_q;
  logic [6:0]       seg_nxt, seg_q;
  logic             dp_q;

  // A new conversion is only accepted while the converter is idle
  assign start = !conv_busy && (bus.score != last_score);

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bus.score),
    .busy  (conv_busy),
    .tens  (tens),
    .units (units)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_score <= '0;
    end else if (start) begin
      last_score <= bus.score;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      slot <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_BLANK;
    case (slot)
      2'd0: begin
        an_nxt  = AN_DIG0;
        seg_nxt = seg_encode(units);
      end
      2'd1: begin
`ifdef SCORE_DISP_LZB_EN
        if (tens != 4'd0) begin
          an_nxt  = AN_DIG1;
          seg_nxt = seg_encode(tens);
        end
`else
        an_nxt  = AN_DIG1;
        seg_nxt = seg_encode(tens);
`endif
      end
      default: begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
      end
    endcase
  end

  // Outputs load once per slot, on the first cycle after the counter wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      dp_q <= 1'b1;
      if (cnt == '0) begin
        an_q  <= an_nxt;
        seg_q <= seg_nxt;
      end
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = dp_q;
  assign bus.busy = conv_busy;

endmodule

// File: tb/tb_score_display.sv
// Randomized self-checking bench for score_display with REFRESH_DIV=4.
// Expected display is derived from score/10, score%10 and the cycle count.
module tb_score_display;

  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  score_display_if sif();

  score_display #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;
  int cur = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  function automatic bit tens_blank(input int val);
`ifdef SCORE_DISP_LZB_EN
    return (val / 10) == 0;
`else
    return 1'b0;
`endif
  endfunction

  // After edge kk (kk>=1) the outputs show slot ((kk-1)/RD) mod 4
  function automatic logic [3:0] exp_an(input int kk, input int val);
    int s;
    s = ((kk - 1) / RD) % 4;
    if (s == 0) return 4'b1110;
    if (s == 1) return tens_blank(val) ? 4'b1111 : 4'b1101;
    return 4'b1111;
  endfunction

  function automatic logic [6:0] exp_seg(input int kk, input int val);
    int s;
    s = ((kk - 1) / RD) % 4;
    if (s == 0) return seg_tab[val % 10];
    if (s == 1) return tens_blank(val) ? 7'b1111111 : seg_tab[val / 10];
    return 7'b1111111;
  endfunction

  task automatic check_display(input int val);
    for (int i = 0; i < 4 * RD; i++) begin
      tick();
      chk($sformatf("an_%0d", val), 32'(sif.an), 32'(exp_an(k, val)));
      chk($sformatf("seg_%0d", val), 32'(sif.seg), 32'(exp_seg(k, val)));
      chk("dp", 32'(sif.dp), 32'd1);
    end
  endtask

  task automatic wait_conv(input string tag, input int exp_rise);
    int r;
    int len;
    r = 0;
    len = 0;
    while (!sif.busy && r < 20) begin
      tick();
      r++;
    end
    chk({tag, "_rise"}, 32'(r), 32'(exp_rise));
    while (sif.busy && len < 20) begin
      tick();
      len++;
    end
    chk({tag, "_len"}, 32'(len), 32'd7);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_an"}, 32'(sif.an), 32'hf);
    chk({tag, "_seg"}, 32'(sif.seg), 32'h7f);
    chk({tag, "_dp"}, 32'(sif.dp), 32'd1);
    chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
  endtask

  task automatic new_score(input int v);
    sif.score = 6'(v);
    if (v == cur) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("same_busy", 32'(sif.busy), 32'd0);
      end
    end else begin
      wait_conv($sformatf("conv%0d", v), 1);
      cur = v;
      repeat (4 * RD) tick();
      check_display(cur);
    end
  endtask

  initial begin
    int r;
    int len;
    int v;
    sif.score = 6'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    reset_vals("rst");

    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("zero_busy", 32'(sif.busy), 32'd0);
    end
    check_display(0);

    new_score(42);

    // 12, then 35 arrives three cycles into the first conversion
    sif.score = 6'd12;
    r = 0;
    while (!sif.busy && r < 20) begin
      tick();
      r++;
    end
    chk("s12_rise", 32'(r), 32'd1);
    repeat (3) tick();
    sif.score = 6'd35;
    len = 0;
    while (sif.busy && len < 20) begin
      tick();
      len++;
    end
    chk("s12_len", 32'(len + 3), 32'd7);
    chk("s12_tens", 32'(dut.tens), 32'd1);
    chk("s12_units", 32'(dut.units), 32'd2);
    wait_conv("s35", 1);
    cur = 35;
    repeat (4 * RD) tick();
    check_display(35);

    new_score(7);
    new_score(60);
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 63));
      new_score(v);
    end

    // Reset in the 4th SHIFT cycle of a conversion of 63
    if (cur == 63) new_score(0);
    sif.score = 6'd63;
    r = 0;
    while (!sif.busy && r < 20) begin
      tick();
      r++;
    end
    chk("s63_rise", 32'(r), 32'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    chk("midrst_tens", 32'(dut.tens), 32'd0);
    chk("midrst_units", 32'(dut.units), 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    wait_conv("rst63", 1);
    cur = 63;
    repeat (4 * RD) tick();
    check_display(63);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
